// File: rtl/intf2_all_out_driver_if.sv
// intf2: a two-bit {abc, def} link.
// The producer drives both bits through all_out, and consumers sample them through all_in.
interface intf2;
    logic abc;
    logic def;

    modport all_out (output abc, output def);
    modport all_in  (input  abc, input  def);
endinterface

// File: rtl/intf2_all_out_driver.sv
// intf2_all_out_driver: the producer end of intf2.
// Words arrive as {abc, def} over a valid/ready handshake and are queued in a small FIFO.
// Each word is then shown on drv_port for HOLD_CYCLES cycles, in arrival order.
// When no word is being shown, abc/def carry the idle values.
module intf2_all_out_driver #(
    parameter int   DEPTH       = 4,
    parameter int   HOLD_CYCLES = 3,
    parameter logic IDLE_ABC    = 1'b0,
    parameter logic IDLE_DEF    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_abc,
    input  logic                       in_def,
    intf2.all_out                      drv_port,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    // Keep the hold counter at least one bit wide, even when HOLD_CYCLES is 1.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // FIFO storage. Each entry is packed as {abc, def}.
    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;

    // Presentation state
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             abc_reg;
    logic             def_reg;

    logic             push_en;
    logic             pop_en;
    logic [1:0]       head_word;

    // in_ready depends only on the current occupancy and reset.
    // A pop in the same cycle never frees a slot early.
    assign in_ready  = !rst && (level_reg != FULL_LEVEL);
    assign push_en   = in_valid && in_ready;
    assign head_word = mem[rd_ptr_reg];

    // Decide whether the head word moves onto the bus at the coming edge.
    always_comb begin
        pop_en = 1'b0;
        if (level_reg != '0) begin
            if (state_reg == ST_IDLE) begin
                pop_en = 1'b1;
            end else if (cnt_reg == '0) begin
                pop_en = 1'b1;
            end
        end
    end

    // Occupancy update.
    // When a push and a pop happen together, the level stays the same.
    always_comb begin
        level_next = level_reg;
        case ({push_en, pop_en})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Write port of the storage array. The array itself is not reset, because only the pointers matter.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= {in_abc, in_def};
        end
    end

    // FIFO pointers and level.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
        end
    end

    // Presentation FSM. abc/def are registered, and the FIFO read lands directly in them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            abc_reg   <= IDLE_ABC;
            def_reg   <= IDLE_DEF;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop_en) begin
                        abc_reg   <= head_word[1];
                        def_reg   <= head_word[0];
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= ST_HOLD;
                    end else begin
                        abc_reg <= IDLE_ABC;
                        def_reg <= IDLE_DEF;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (pop_en) begin
                        // Load the next word with no idle cycle in between.
                        abc_reg <= head_word[1];
                        def_reg <= head_word[0];
                        cnt_reg <= HOLD_LOAD;
                    end else begin
                        abc_reg   <= IDLE_ABC;
                        def_reg   <= IDLE_DEF;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    abc_reg   <= IDLE_ABC;
                    def_reg   <= IDLE_DEF;
                end
            endcase
        end
    end

    assign drv_port.abc = abc_reg;
    assign drv_port.def = def_reg;
    assign busy         = (state_reg == ST_HOLD);
    assign level        = level_reg;

endmodule

// File: tb/tb_intf2_all_out_driver.sv
// Bench for intf2_all_out_driver. It runs two instances on the same stimulus:
//   a: DEPTH=4, HOLD_CYCLES=3, idle values {0,0}
//   b: DEPTH=4, HOLD_CYCLES=1 (streaming), idle values {1,0}
// The reference model keeps each FIFO as a queue.
// It tracks the word on the bus together with the number of visible cycles it has left.
module tb_intf2_all_out_driver;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_abc   = 1'b0;
    logic             in_def   = 1'b0;
    logic             in_ready_a, busy_a;
    logic             in_ready_b, busy_b;
    logic [LVL_W-1:0] level_a, level_b;

    intf2 bus_a ();
    intf2 bus_b ();

    intf2_all_out_driver #(
        .DEPTH(DEPTH), .HOLD_CYCLES(3), .IDLE_ABC(1'b0), .IDLE_DEF(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_abc(in_abc), .in_def(in_def), .drv_port(bus_a.all_out),
        .busy(busy_a), .level(level_a)
    );

    intf2_all_out_driver #(
        .DEPTH(DEPTH), .HOLD_CYCLES(1), .IDLE_ABC(1'b1), .IDLE_DEF(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_abc(in_abc), .in_def(in_def), .drv_port(bus_b.all_out),
        .busy(busy_b), .level(level_b)
    );

    // Reference model state
    logic [1:0] qa [$];
    logic [1:0] qb [$];
    bit         pres     [2] = '{0, 0};
    int         rem      [2] = '{0, 0};
    logic [1:0] cur      [2] = '{2'b00, 2'b00};
    int         hold_of  [2] = '{3, 1};
    logic       idle_abc [2] = '{1'b0, 1'b1};
    logic       idle_def [2] = '{1'b0, 1'b0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_push_a = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? qa.size() : qb.size();
    endfunction

    task automatic q_pop(input int k, output logic [1:0] w);
        if (k == 0) w = qa.pop_front();
        else        w = qb.pop_front();
    endtask

    task automatic q_push(input int k, input logic [1:0] w);
        if (k == 0) qa.push_back(w);
        else        qb.push_back(w);
    endtask

    task automatic q_clear(input int k);
        if (k == 0) qa.delete();
        else        qb.delete();
    endtask

    // Advance both models by one clock edge, using the inputs present at that edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit ready;
            int sz;
            logic [1:0] w;
            sz    = q_size(k);
            ready = !rst && (sz != DEPTH);
            if (rst) begin
                q_clear(k);
                pres[k] = 0;
                rem[k]  = 0;
            end else begin
                if (pres[k] && rem[k] > 1) begin
                    rem[k]--;
                end else if (sz > 0) begin
                    q_pop(k, w);
                    cur[k]  = w;
                    pres[k] = 1;
                    rem[k]  = hold_of[k];
                end else begin
                    pres[k] = 0;
                    rem[k]  = 0;
                end
                if (in_valid && ready) begin
                    q_push(k, {in_abc, in_def});
                    if (k == 0) begin
                        n_push_a++;
                        $display("push a #%0d abc=%0d def=%0d", n_push_a, in_abc, in_def);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string nm;
            int g_abc, g_def, g_busy, g_lvl, g_rdy;
            int e_abc, e_def;
            nm     = (k == 0) ? "a" : "b";
            g_abc  = (k == 0) ? int'(bus_a.abc)  : int'(bus_b.abc);
            g_def  = (k == 0) ? int'(bus_a.def)  : int'(bus_b.def);
            g_busy = (k == 0) ? int'(busy_a)     : int'(busy_b);
            g_lvl  = (k == 0) ? int'(level_a)    : int'(level_b);
            g_rdy  = (k == 0) ? int'(in_ready_a) : int'(in_ready_b);
            e_abc  = pres[k] ? int'(cur[k][1]) : int'(idle_abc[k]);
            e_def  = pres[k] ? int'(cur[k][0]) : int'(idle_def[k]);
            check({nm, ".abc"},      g_abc,  e_abc);
            check({nm, ".def"},      g_def,  e_def);
            check({nm, ".busy"},     g_busy, int'(pres[k]));
            check({nm, ".level"},    g_lvl,  q_size(k));
            check({nm, ".in_ready"}, g_rdy,  int'(!rst && q_size(k) != DEPTH));
        end
    endtask

    // One clock: drive the inputs, step the model at the edge, then compare on the falling edge.
    task automatic cycle(input logic r, input logic v, input logic a, input logic d);
        rst      = r;
        in_valid = v;
        in_abc   = a;
        in_def   = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        // Reset with in_valid held high: nothing may be captured.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);

        // Single word {1,0}
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Three back-to-back words
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous offer of 6 words, which fills FIFO a and exercises backpressure
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Ten alternating words, which wrap the pointers
        for (int i = 0; i < 10; i++) begin
            logic bit_v;
            bit_v = 1'(i);
            cycle(1'b0, 1'b1, bit_v, ~bit_v);
        end
        repeat (35) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while the first of three queued words is still being held
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (15) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r, v;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            cycle(r, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
